// File: rtl/rsc_pkg.sv
// Shared definitions for the RISC core: opcodes, ALU function codes,
// instruction field positions, the control word and the opcode decoder.
package rsc_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned FSW  = 5;
  localparam int unsigned OPW  = 7;
  localparam int unsigned IMMW = 15;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 25;
  localparam int unsigned DR_MSB  = 24;
  localparam int unsigned DR_LSB  = 20;
  localparam int unsigned SA_MSB  = 19;
  localparam int unsigned SA_LSB  = 15;
  localparam int unsigned SB_MSB  = 14;
  localparam int unsigned SB_LSB  = 10;
  localparam int unsigned IMM_MSB = 14;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OPW-1:0] OP_NOP = 7'b0000000;
  localparam logic [OPW-1:0] OP_ADD = 7'b0000010;
  localparam logic [OPW-1:0] OP_SUB = 7'b0000101;
  localparam logic [OPW-1:0] OP_AND = 7'b0001000;
  localparam logic [OPW-1:0] OP_OR  = 7'b0001001;
  localparam logic [OPW-1:0] OP_ADI = 7'b0100010;
  localparam logic [OPW-1:0] OP_LD  = 7'b0100001;
  localparam logic [OPW-1:0] OP_ST  = 7'b0000001;
  localparam logic [OPW-1:0] OP_JML = 7'b0110111;

  localparam logic [FSW-1:0] FS_PASS_A = 5'b00000;
  localparam logic [FSW-1:0] FS_ADD    = 5'b00010;
  localparam logic [FSW-1:0] FS_SUB    = 5'b00101;
  localparam logic [FSW-1:0] FS_AND    = 5'b01000;
  localparam logic [FSW-1:0] FS_OR     = 5'b01001;

  typedef struct packed {
    logic           ma;
    logic           mb;
    logic           cs;
    logic           rw;
    logic           md;
    logic           mw;
    logic [FSW-1:0] fs;
  } ctrl_t;

  // Unknown opcodes fall through to an all-zero (NOP) control word.
  function automatic ctrl_t decode(input logic [OPW-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD: begin c.fs = FS_ADD; c.rw = 1'b1; end
      OP_SUB: begin c.fs = FS_SUB; c.rw = 1'b1; end
      OP_AND: begin c.fs = FS_AND; c.rw = 1'b1; end
      OP_OR:  begin c.fs = FS_OR;  c.rw = 1'b1; end
      OP_ADI: begin c.fs = FS_ADD; c.mb = 1'b1; c.cs = 1'b1; c.rw = 1'b1; end
      OP_LD:  begin c.fs = FS_PASS_A; c.md = 1'b1; c.rw = 1'b1; end
      OP_ST:  begin c.fs = FS_PASS_A; c.mw = 1'b1; end
      OP_JML: begin c.fs = FS_PASS_A; c.ma = 1'b1; c.rw = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: R0 is zero, then EX forward (non-load),
// then write-back forward, otherwise the register-file read data.
module operand_fwd_mux
  import rsc_pkg::*;
(
  input  logic [AW-1:0] src,
  input  logic [DW-1:0] rf_data,
  input  logic          ex_fwd_rw,
  input  logic [AW-1:0] ex_fwd_da,
  input  logic          ex_fwd_md,
  input  logic [DW-1:0] ex_fwd_data,
  input  logic          wb_rw,
  input  logic [AW-1:0] wb_da,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] operand_c
);

  always_comb begin
    operand_c = rf_data;
    if (src == '0) begin
      operand_c = '0;
    end else if (ex_fwd_rw && (ex_fwd_da == src) && !ex_fwd_md) begin
      operand_c = ex_fwd_data;
    end else if (wb_rw && (wb_da == src)) begin
      operand_c = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: IR latch, decode, operand forwarding,
// load-use stall and the DOF/EX pipeline register.
module operand_fetch_stage
  import rsc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           if_valid,
  input  logic [DW-1:0]  if_ir,
  input  logic [DW-1:0]  if_pc_1,
  output logic           if_stall,
  output logic [AW-1:0]  rf_aa,
  output logic [AW-1:0]  rf_ba,
  input  logic [DW-1:0]  rf_a,
  input  logic [DW-1:0]  rf_b,
  input  logic           ex_fwd_rw,
  input  logic [AW-1:0]  ex_fwd_da,
  input  logic           ex_fwd_md,
  input  logic [DW-1:0]  ex_fwd_data,
  input  logic           wb_rw,
  input  logic [AW-1:0]  wb_da,
  input  logic [DW-1:0]  wb_data,
  input  logic           flush,
  output logic           ex_valid,
  output logic           ex_rw,
  output logic           ex_md,
  output logic           ex_mw,
  output logic [AW-1:0]  ex_da,
  output logic [FSW-1:0] ex_fs,
  output logic [DW-1:0]  ex_bus_a,
  output logic [DW-1:0]  ex_bus_b,
  output logic [DW-1:0]  ex_pc_1
);

  logic [DW-1:0] ir;
  logic [DW-1:0] pc_1;
  logic          ir_valid;

  ctrl_t         ctrl;
  logic [AW-1:0] sa;
  logic [AW-1:0] sb;
  logic [DW-1:0] const_val;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;
  logic [DW-1:0] bus_a;
  logic [DW-1:0] bus_b;
  logic          load_use;
  logic          bubble;

  assign ctrl  = decode(ir[OP_MSB:OP_LSB]);
  assign sa    = ir[SA_MSB:SA_LSB];
  assign sb    = ir[SB_MSB:SB_LSB];
  assign rf_aa = sa;
  assign rf_ba = sb;

  assign const_val = ctrl.cs ? {{(DW-IMMW){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]}
                             : {{(DW-IMMW){1'b0}},        ir[IMM_MSB:IMM_LSB]};

  operand_fwd_mux u_fwd_a (
    .src         (sa),
    .rf_data     (rf_a),
    .ex_fwd_rw   (ex_fwd_rw),
    .ex_fwd_da   (ex_fwd_da),
    .ex_fwd_md   (ex_fwd_md),
    .ex_fwd_data (ex_fwd_data),
    .wb_rw       (wb_rw),
    .wb_da       (wb_da),
    .wb_data     (wb_data),
    .operand_c   (opnd_a)
  );

  operand_fwd_mux u_fwd_b (
    .src         (sb),
    .rf_data     (rf_b),
    .ex_fwd_rw   (ex_fwd_rw),
    .ex_fwd_da   (ex_fwd_da),
    .ex_fwd_md   (ex_fwd_md),
    .ex_fwd_data (ex_fwd_data),
    .wb_rw       (wb_rw),
    .wb_da       (wb_da),
    .wb_data     (wb_data),
    .operand_c   (opnd_b)
  );

  assign bus_a = ctrl.ma ? pc_1 : opnd_a;
  assign bus_b = ctrl.mb ? const_val : opnd_b;

  // A load in EX cannot forward yet; stall if a source actually consumed here matches it.
  assign load_use = ir_valid && ex_fwd_md && ex_fwd_rw && (ex_fwd_da != '0) &&
                    ((!ctrl.ma && (ex_fwd_da == sa)) ||
                     ((!ctrl.mb || ctrl.mw) && (ex_fwd_da == sb)));

  assign if_stall = load_use && !flush;
  assign bubble   = flush || !ir_valid || load_use;

  // IR latch; a flush still captures fetch but marks it invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      pc_1     <= '0;
      ir_valid <= 1'b0;
    end else if (!if_stall) begin
      ir       <= if_ir;
      pc_1     <= if_pc_1;
      ir_valid <= if_valid && !flush;
    end
  end

  // DOF/EX register; bubbles load as all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_rw    <= 1'b0;
      ex_md    <= 1'b0;
      ex_mw    <= 1'b0;
      ex_da    <= '0;
      ex_fs    <= '0;
      ex_bus_a <= '0;
      ex_bus_b <= '0;
      ex_pc_1  <= '0;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_rw    <= 1'b0;
      ex_md    <= 1'b0;
      ex_mw    <= 1'b0;
      ex_da    <= '0;
      ex_fs    <= '0;
      ex_bus_a <= '0;
      ex_bus_b <= '0;
      ex_pc_1  <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_rw    <= ctrl.rw;
      ex_md    <= ctrl.md;
      ex_mw    <= ctrl.mw;
      ex_da    <= ir[DR_MSB:DR_LSB];
      ex_fs    <= ctrl.fs;
      ex_bus_a <= bus_a;
      ex_bus_b <= bus_b;
      ex_pc_1  <= pc_1;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: expected DOF/EX contents are
// queued when an instruction's operands are driven and checked after the edge.
module tb_operand_fetch_stage;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        md;
    logic        mw;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_ir = '0;
  logic [31:0] if_pc_1 = '0;
  logic        if_stall;
  logic [4:0]  rf_aa, rf_ba;
  logic [31:0] rf_a = '0, rf_b = '0;
  logic        ex_fwd_rw = 1'b0, ex_fwd_md = 1'b0;
  logic [4:0]  ex_fwd_da = '0;
  logic [31:0] ex_fwd_data = '0;
  logic        wb_rw = 1'b0;
  logic [4:0]  wb_da = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        ex_valid, ex_rw, ex_md, ex_mw;
  logic [4:0]  ex_da, ex_fs;
  logic [31:0] ex_bus_a, ex_bus_b, ex_pc_1;

  int  checks = 0;
  int  failures = 0;
  ex_t sb_q[$];

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ir(if_ir), .if_pc_1(if_pc_1),
    .if_stall(if_stall), .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_a(rf_a), .rf_b(rf_b),
    .ex_fwd_rw(ex_fwd_rw), .ex_fwd_da(ex_fwd_da), .ex_fwd_md(ex_fwd_md),
    .ex_fwd_data(ex_fwd_data), .wb_rw(wb_rw), .wb_da(wb_da), .wb_data(wb_data),
    .flush(flush), .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_md(ex_md), .ex_mw(ex_mw),
    .ex_da(ex_da), .ex_fs(ex_fs), .ex_bus_a(ex_bus_a), .ex_bus_b(ex_bus_b),
    .ex_pc_1(ex_pc_1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] dr,
                                      input logic [4:0] sa, input logic [14:0] low);
    return {op, dr, sa, low};
  endfunction

  function automatic ex_t mk(input logic v, input logic rw, input logic md, input logic mw,
                             input logic [4:0] da, input logic [4:0] fs,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    return {v, rw, md, mw, da, fs, a, b, pc};
  endfunction

  function automatic ex_t ex_now();
    return {ex_valid, ex_rw, ex_md, ex_mw, ex_da, ex_fs, ex_bus_a, ex_bus_b, ex_pc_1};
  endfunction

  task automatic idle();
    if_valid = 1'b0; flush = 1'b0;
    ex_fwd_rw = 1'b0; ex_fwd_md = 1'b0; ex_fwd_da = '0; ex_fwd_data = '0;
    wb_rw = 1'b0; wb_da = '0; wb_data = '0;
    rf_a = '0; rf_b = '0;
  endtask

  task automatic fetch(input logic [31:0] ir, input logic [31:0] pc);
    if_ir = ir; if_pc_1 = pc; if_valid = 1'b1;
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  task automatic test_reset();
    ex_t got;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = ex_now();
    checks++;
    if (got !== '0 || if_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%h stall=%b expected=0 stall=0", got, if_stall);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    ex_t got, exp;
    fetch(enc(7'b0000010, 5'd3, 5'd1, {5'd2, 10'd0}), 32'h100);
    rf_a = 32'd5; rf_b = 32'd7;
    #1;
    checks++;
    if (rf_aa !== 5'd1 || rf_ba !== 5'd2) begin
      failures++;
      $display("FAIL add_rf_addr got aa=%0d ba=%0d expected aa=1 ba=2", rf_aa, rf_ba);
    end
    sb_q.push_back(mk(1, 1, 0, 0, 5'd3, 5'b00010, 32'd5, 32'd7, 32'h100));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = ex_now();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL add_basic got=%h expected=%h", got, exp);
    end
    idle();
  endtask

  task automatic test_adi();
    ex_t got, exp;
    logic [14:0] imm [2];
    logic [31:0] want [2];
    imm  = '{15'h7FFF, 15'h0005};
    want = '{32'hFFFF_FFFF, 32'h0000_0005};
    for (int k = 0; k < 2; k++) begin
      fetch(enc(7'b0100010, 5'd4, 5'd1, imm[k]), 32'h110 + 32'(k));
      rf_a = 32'h1000; rf_b = 32'h9999;
      sb_q.push_back(mk(1, 1, 0, 0, 5'd4, 5'b00010, 32'h1000, want[k], 32'h110 + 32'(k)));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = ex_now();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL adi_imm%0d got=%h expected=%h", k, got, exp);
      end
      idle();
    end
  endtask

  task automatic test_forward();
    ex_t got, exp;
    for (int c = 0; c < 4; c++) begin
      fetch(enc(7'b0000010, 5'd5, (c == 2) ? 5'd0 : 5'd1, {5'd2, 10'd0}), 32'h120 + 32'(c));
      rf_a = 32'hAA; rf_b = 32'hBB;
      case (c)
        0: begin
          ex_fwd_rw = 1; ex_fwd_da = 5'd1; ex_fwd_data = 32'h10;
          wb_rw = 1; wb_da = 5'd1; wb_data = 32'h20;
          exp = mk(1, 1, 0, 0, 5'd5, 5'b00010, 32'h10, 32'hBB, 32'h120);
        end
        1: begin
          wb_rw = 1; wb_da = 5'd1; wb_data = 32'h20;
          exp = mk(1, 1, 0, 0, 5'd5, 5'b00010, 32'h20, 32'hBB, 32'h121);
        end
        2: begin
          rf_a = 32'h77;
          ex_fwd_rw = 1; ex_fwd_da = 5'd0; ex_fwd_data = 32'h55;
          wb_rw = 1; wb_da = 5'd0; wb_data = 32'h66;
          exp = mk(1, 1, 0, 0, 5'd5, 5'b00010, 32'h0, 32'hBB, 32'h122);
        end
        default: begin
          ex_fwd_rw = 1; ex_fwd_da = 5'd2; ex_fwd_data = 32'h33;
          exp = mk(1, 1, 0, 0, 5'd5, 5'b00010, 32'hAA, 32'h33, 32'h123);
        end
      endcase
      sb_q.push_back(exp);
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = ex_now();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL forward_case%0d got=%h expected=%h", c, got, exp);
      end
      idle();
    end
  endtask

  task automatic test_load_use();
    ex_t got, exp;
    fetch(enc(7'b0000001, 5'd0, 5'd3, {5'd2, 10'd0}), 32'h300);
    if_ir = enc(7'b0000010, 5'd9, 5'd1, {5'd4, 10'd0});
    rf_a = 32'h3333; rf_b = 32'h0BAD;
    ex_fwd_rw = 1; ex_fwd_md = 1; ex_fwd_da = 5'd2; ex_fwd_data = 32'hEEEE;
    #1;
    checks++;
    if (if_stall !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall got=%b expected=1", if_stall);
    end
    sb_q.push_back(mk(0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = ex_now();
    checks++;
    if ({got.valid, got.rw, got.md, got.mw} !== {exp.valid, exp.rw, exp.md, exp.mw}) begin
      failures++;
      $display("FAIL load_use_bubble got=%b expected=%b",
               {got.valid, got.rw, got.md, got.mw}, {exp.valid, exp.rw, exp.md, exp.mw});
    end
    checks++;
    if (rf_aa !== 5'd3 || rf_ba !== 5'd2) begin
      failures++;
      $display("FAIL load_use_ir_held got aa=%0d ba=%0d expected aa=3 ba=2", rf_aa, rf_ba);
    end
    ex_fwd_md = 0; ex_fwd_data = 32'h99;
    #1;
    checks++;
    if (if_stall !== 1'b0) begin
      failures++;
      $display("FAIL load_use_release got=%b expected=0", if_stall);
    end
    sb_q.push_back(mk(1, 0, 0, 1, 5'd0, 5'd0, 32'h3333, 32'h99, 32'h300));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = ex_now();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL load_use_fwd got=%h expected=%h", got, exp);
    end
    idle();
  endtask

  task automatic test_flush();
    ex_t got, exp;
    fetch(enc(7'b0000001, 5'd0, 5'd3, {5'd2, 10'd0}), 32'h310);
    ex_fwd_rw = 1; ex_fwd_md = 1; ex_fwd_da = 5'd2;
    flush = 1;
    if_ir = enc(7'b0000010, 5'd7, 5'd1, {5'd2, 10'd0}); if_pc_1 = 32'h311; if_valid = 1;
    #1;
    checks++;
    if (if_stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall got=%b expected=0", if_stall);
    end
    sb_q.push_back(mk(0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = ex_now();
    checks++;
    if ({got.valid, got.rw, got.md, got.mw} !== {exp.valid, exp.rw, exp.md, exp.mw}) begin
      failures++;
      $display("FAIL flush_bubble got=%b expected=%b",
               {got.valid, got.rw, got.md, got.mw}, {exp.valid, exp.rw, exp.md, exp.mw});
    end
    idle();
    sb_q.push_back(mk(0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = ex_now();
    checks++;
    if ({got.valid, got.rw, got.md, got.mw} !== {exp.valid, exp.rw, exp.md, exp.mw}) begin
      failures++;
      $display("FAIL flush_discard got=%b expected=%b",
               {got.valid, got.rw, got.md, got.mw}, {exp.valid, exp.rw, exp.md, exp.mw});
    end
  endtask

  task automatic test_back_to_back();
    ex_t got, exp;
    logic [31:0] irs [6];
    logic [31:0] ra  [6];
    logic [31:0] rb  [6];
    ex_t         want [6];
    irs[0] = enc(7'b0000101, 5'd8,  5'd9,  {5'd10, 10'd0});
    irs[1] = enc(7'b0001000, 5'd11, 5'd12, {5'd13, 10'd0});
    irs[2] = enc(7'b0001001, 5'd14, 5'd15, {5'd16, 10'd0});
    irs[3] = enc(7'b0110111, 5'd31, 5'd1,  {5'd2,  10'd0});
    irs[4] = enc(7'b1111111, 5'd5,  5'd1,  {5'd2,  10'd0});
    irs[5] = enc(7'b0100001, 5'd6,  5'd7,  {5'd8,  10'd0});
    ra = '{32'h30, 32'hF0F0, 32'h1, 32'hDEAD, 32'h3, 32'h1234};
    rb = '{32'h10, 32'h0FF0, 32'h2, 32'h44,   32'h4, 32'h9};
    want[0] = mk(1, 1, 0, 0, 5'd8,  5'b00101, 32'h30,   32'h10,   32'h200);
    want[1] = mk(1, 1, 0, 0, 5'd11, 5'b01000, 32'hF0F0, 32'h0FF0, 32'h201);
    want[2] = mk(1, 1, 0, 0, 5'd14, 5'b01001, 32'h1,    32'h2,    32'h202);
    want[3] = mk(1, 1, 0, 0, 5'd31, 5'b00000, 32'h203,  32'h44,   32'h203);
    want[4] = mk(1, 0, 0, 0, 5'd5,  5'b00000, 32'h3,    32'h4,    32'h204);
    want[5] = mk(1, 1, 1, 0, 5'd6,  5'b00000, 32'h1234, 32'h9,    32'h205);
    if_ir = irs[0]; if_pc_1 = 32'h200; if_valid = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      rf_a = ra[k]; rf_b = rb[k];
      sb_q.push_back(want[k]);
      if (k < 5) begin
        if_ir = irs[k+1]; if_pc_1 = 32'h200 + 32'(k + 1);
      end else begin
        if_valid = 0;
      end
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = ex_now();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_%0d got=%h expected=%h", k, got, exp);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    ex_t got, exp;
    fetch(enc(7'b0000010, 5'd3, 5'd1, {5'd2, 10'd0}), 32'h400);
    rf_a = 32'h1; rf_b = 32'h2;
    sb_q.push_back(mk(1, 1, 0, 0, 5'd3, 5'b00010, 32'h1, 32'h2, 32'h400));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = ex_now();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL pre_reset got=%h expected=%h", got, exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = ex_now();
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h expected=0", got);
    end
    idle();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(enc(7'b0000010, 5'd9, 5'd1, {5'd2, 10'd0}), 32'h500);
    rf_a = 32'h11; rf_b = 32'h22;
    sb_q.push_back(mk(1, 1, 0, 0, 5'd9, 5'b00010, 32'h11, 32'h22, 32'h500));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = ex_now();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL post_reset got=%h expected=%h", got, exp);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_adi();
    test_forward();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
